// File: rtl/sm83_bus_responder_if.sv
// sm83_bus_responder_if
// Bundles the CPU-side bus pins and the synchronous RAM port of the SM83
// target-side responder.
//   slave  : the responder itself (takes CPU requests, drives the RAM port)
//   master : its surroundings (the CPU driving requests plus the RAM model
//            returning mem_rdata)
// Signals:
//   cpu_adr/cpu_rd/cpu_wr/cpu_wdata  CPU request (level, held until ack)
//   cpu_rdata/cpu_hit/cpu_busy/cpu_ack/err  responder status back to CPU
//   mem_adr/mem_ce/mem_we/mem_wdata  RAM command, mem_rdata RAM read data
interface sm83_bus_responder_if #(
  parameter int unsigned ADR_WIDTH  = 16,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned SIZE_LOG2  = 13
);
  logic [ADR_WIDTH-1:0]  cpu_adr;
  logic                  cpu_rd;
  logic                  cpu_wr;
  logic [DATA_WIDTH-1:0] cpu_wdata;
  logic [DATA_WIDTH-1:0] cpu_rdata;
  logic                  cpu_hit;
  logic                  cpu_busy;
  logic                  cpu_ack;
  logic                  err;
  logic [SIZE_LOG2-1:0]  mem_adr;
  logic                  mem_ce;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  cpu_adr, cpu_rd, cpu_wr, cpu_wdata, mem_rdata,
    output cpu_rdata, cpu_hit, cpu_busy, cpu_ack, err,
           mem_adr, mem_ce, mem_we, mem_wdata
  );

  modport master (
    output cpu_adr, cpu_rd, cpu_wr, cpu_wdata, mem_rdata,
    input  cpu_rdata, cpu_hit, cpu_busy, cpu_ack, err,
           mem_adr, mem_ce, mem_we, mem_wdata
  );
endinterface

// File: rtl/sm83_bus_responder.sv
// sm83_bus_responder
// Target-side end of the SM83 external address/data bus. A request whose
// address falls in the aligned window [BASE, BASE + 2**SIZE_LOG2) is turned
// into exactly one access on a 1-cycle-latency synchronous RAM port, then
// acknowledged with a one-cycle cpu_ack pulse.
// Ports:
//   clk      clock, all state updates on the rising edge
//   reset_n  asynchronous active-low reset
//   bus      sm83_bus_responder_if.slave (CPU request/status + RAM port)
// Timing: request sampled in IDLE at cycle n -> mem_ce in n+1,
//   cpu_ack in n+3+WAIT_STATES, for reads and writes alike.
module sm83_bus_responder #(
  parameter int unsigned ADR_WIDTH   = 16,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned BASE        = 'hC000,
  parameter int unsigned SIZE_LOG2   = 13,
  parameter int unsigned WAIT_STATES = 0
) (
  input logic clk,
  input logic reset_n,
  sm83_bus_responder_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MEM,
    S_LAT,
    S_WAIT,
    S_ACK,
    S_HOLD
  } state_t;

  localparam logic [ADR_WIDTH-1:0] BASE_ADR = ADR_WIDTH'(BASE);
  // The counter counts down to zero inclusive, so it is loaded one short.
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t                state_q, state_d;
  logic [SIZE_LOG2-1:0]  adr_q, adr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  op_write_q, op_write_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic [3:0]            cnt_q, cnt_d;

  logic hit;
  logic mem_ce;
  logic mem_we;
  logic cpu_ack;
  logic cpu_busy;

  // Window decode: only the bits above the window size take part, which is
  // why BASE must be aligned to the window size.
  assign hit = (bus.cpu_adr[ADR_WIDTH-1:SIZE_LOG2] == BASE_ADR[ADR_WIDTH-1:SIZE_LOG2]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      adr_q      <= '0;
      wdata_q    <= '0;
      op_write_q <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      cnt_q      <= 4'd0;
    end else begin
      state_q    <= state_d;
      adr_q      <= adr_d;
      wdata_q    <= wdata_d;
      op_write_q <= op_write_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    adr_d      = adr_q;
    wdata_d    = wdata_q;
    op_write_d = op_write_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    case (state_q)
      S_IDLE: begin
        // Simultaneous rd and wr on a hit is a protocol error: flag it and
        // perform no access. Misses are ignored entirely.
        if (hit) begin
          if (bus.cpu_rd && bus.cpu_wr) begin
            err_d = 1'b1;
          end else if (bus.cpu_rd || bus.cpu_wr) begin
            adr_d      = bus.cpu_adr[SIZE_LOG2-1:0];
            wdata_d    = bus.cpu_wdata;
            op_write_d = bus.cpu_wr;
            state_d    = S_MEM;
          end
        end
      end
      S_MEM: state_d = S_LAT;
      S_LAT: begin
        // RAM data issued in MEM is valid during this cycle.
        if (!op_write_q) begin
          rdata_d = bus.mem_rdata;
        end
        if (WAIT_STATES > 0) begin
          cnt_d   = WAIT_LOAD;
          state_d = S_WAIT;
        end else begin
          state_d = S_ACK;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_ACK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ACK: begin
        // A still-asserted level request must not start a second access.
        state_d = (bus.cpu_rd || bus.cpu_wr) ? S_HOLD : S_IDLE;
      end
      S_HOLD: begin
        if (!bus.cpu_rd && !bus.cpu_wr) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_ce   = 1'b0;
    mem_we   = 1'b0;
    cpu_ack  = 1'b0;
    cpu_busy = 1'b0;
    case (state_q)
      S_MEM: begin
        mem_ce   = 1'b1;
        mem_we   = op_write_q;
        cpu_busy = 1'b1;
      end
      S_LAT, S_WAIT: cpu_busy = 1'b1;
      S_ACK: begin
        cpu_ack  = 1'b1;
        cpu_busy = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.cpu_hit   = hit;
  assign bus.cpu_rdata = rdata_q;
  assign bus.cpu_busy  = cpu_busy;
  assign bus.cpu_ack   = cpu_ack;
  assign bus.err       = err_q;
  assign bus.mem_adr   = adr_q;
  assign bus.mem_ce    = mem_ce;
  assign bus.mem_we    = mem_we;
  assign bus.mem_wdata = wdata_q;

endmodule

// File: tb/tb_sm83_bus_responder.sv
// tb_sm83_bus_responder
// Directed bench for sm83_bus_responder. Three instances share clock and
// reset: u0 (no wait states), u2 (2 wait states) and u3 (3 wait states),
// each backed by a 1-cycle-latency RAM model in the bench. Inputs change
// #1 after a rising edge or on a falling edge; outputs are sampled on
// falling edges. Cycle k=0 is the cycle in which the responder first
// samples a freshly driven request.
module tb_sm83_bus_responder;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sm83_bus_responder_if #(.ADR_WIDTH(16), .DATA_WIDTH(8), .SIZE_LOG2(13)) bus0 ();
  sm83_bus_responder_if #(.ADR_WIDTH(16), .DATA_WIDTH(8), .SIZE_LOG2(13)) bus2 ();
  sm83_bus_responder_if #(.ADR_WIDTH(16), .DATA_WIDTH(8), .SIZE_LOG2(13)) bus3 ();

  sm83_bus_responder #(.ADR_WIDTH(16), .DATA_WIDTH(8), .BASE('hC000), .SIZE_LOG2(13),
    .WAIT_STATES(0)) u0 (.clk(clk), .reset_n(reset_n), .bus(bus0));
  sm83_bus_responder #(.ADR_WIDTH(16), .DATA_WIDTH(8), .BASE('hC000), .SIZE_LOG2(13),
    .WAIT_STATES(2)) u2 (.clk(clk), .reset_n(reset_n), .bus(bus2));
  sm83_bus_responder #(.ADR_WIDTH(16), .DATA_WIDTH(8), .BASE('hC000), .SIZE_LOG2(13),
    .WAIT_STATES(3)) u3 (.clk(clk), .reset_n(reset_n), .bus(bus3));

  logic [7:0] ram0 [0:8191];
  logic [7:0] ram2 [0:8191];
  logic [7:0] ram3 [0:8191];
  bit ram_init = 1'b0;

  // RAM models: read-before-write, data valid the cycle after mem_ce.
  always @(posedge clk) begin
    if (!ram_init) begin
      ram0[13'h0123] = 8'h5A;
      ram0[13'h0010] = 8'h3C;
      ram3[13'h0000] = 8'h77;
      ram_init = 1'b1;
    end
    if (bus0.mem_ce) begin
      bus0.mem_rdata <= ram0[bus0.mem_adr];
      if (bus0.mem_we) ram0[bus0.mem_adr] = bus0.mem_wdata;
    end
    if (bus2.mem_ce) begin
      bus2.mem_rdata <= ram2[bus2.mem_adr];
      if (bus2.mem_we) ram2[bus2.mem_adr] = bus2.mem_wdata;
    end
    if (bus3.mem_ce) begin
      bus3.mem_rdata <= ram3[bus3.mem_adr];
      if (bus3.mem_we) ram3[bus3.mem_adr] = bus3.mem_wdata;
    end
  end

  task automatic idle_all();
    bus0.cpu_adr = 16'h0000; bus0.cpu_rd = 1'b0; bus0.cpu_wr = 1'b0; bus0.cpu_wdata = 8'h00;
    bus2.cpu_adr = 16'h0000; bus2.cpu_rd = 1'b0; bus2.cpu_wr = 1'b0; bus2.cpu_wdata = 8'h00;
    bus3.cpu_adr = 16'h0000; bus3.cpu_rd = 1'b0; bus3.cpu_wr = 1'b0; bus3.cpu_wdata = 8'h00;
  endtask

  // Reset held with random inputs: every registered output stays zero.
  task automatic test_reset();
    reset_n = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus0.cpu_adr = 16'($urandom); bus0.cpu_rd = 1'($urandom); bus0.cpu_wr = 1'($urandom);
      bus0.cpu_wdata = 8'($urandom);
      bus2.cpu_adr = 16'($urandom); bus2.cpu_rd = 1'($urandom); bus2.cpu_wr = 1'($urandom);
      bus2.cpu_wdata = 8'($urandom);
      bus3.cpu_adr = 16'($urandom); bus3.cpu_rd = 1'($urandom); bus3.cpu_wr = 1'($urandom);
      bus3.cpu_wdata = 8'($urandom);
      @(negedge clk);
      checks++;
      if ({bus0.cpu_rdata, bus0.cpu_ack, bus0.cpu_busy, bus0.err, bus0.mem_ce, bus0.mem_we,
           bus0.mem_adr, bus0.mem_wdata} !== 34'd0) begin
        fails++;
        $display("[TB] FAIL reset_u0 k=%0d got ack=%b busy=%b err=%b ce=%b rdata=%h required all zero",
                 k, bus0.cpu_ack, bus0.cpu_busy, bus0.err, bus0.mem_ce, bus0.cpu_rdata);
      end
      checks++;
      if ({bus2.cpu_rdata, bus2.cpu_ack, bus2.cpu_busy, bus2.err, bus2.mem_ce, bus2.mem_we,
           bus2.mem_adr, bus2.mem_wdata} !== 34'd0) begin
        fails++;
        $display("[TB] FAIL reset_u2 k=%0d got ack=%b busy=%b err=%b ce=%b required all zero",
                 k, bus2.cpu_ack, bus2.cpu_busy, bus2.err, bus2.mem_ce);
      end
      checks++;
      if ({bus3.cpu_rdata, bus3.cpu_ack, bus3.cpu_busy, bus3.err, bus3.mem_ce, bus3.mem_we,
           bus3.mem_adr, bus3.mem_wdata} !== 34'd0) begin
        fails++;
        $display("[TB] FAIL reset_u3 k=%0d got ack=%b busy=%b err=%b ce=%b required all zero",
                 k, bus3.cpu_ack, bus3.cpu_busy, bus3.err, bus3.mem_ce);
      end
    end
    idle_all();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Read of C123 (RAM 0123 = 5A) held past ack: ce at k=1, ack at k=3, HOLD.
  task automatic test_read();
    logic [3:0] exp;
    @(posedge clk); #1;
    bus0.cpu_adr = 16'hC123; bus0.cpu_rd = 1'b1; bus0.cpu_wdata = 8'hFF;
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      exp = {k == 1, 1'b0, k == 3, (k >= 1 && k <= 3)};
      checks++;
      if ({bus0.mem_ce, bus0.mem_we, bus0.cpu_ack, bus0.cpu_busy} !== exp) begin
        fails++;
        $display("[TB] FAIL read_ctl k=%0d got ce/we/ack/busy=%b required %b", k,
                 {bus0.mem_ce, bus0.mem_we, bus0.cpu_ack, bus0.cpu_busy}, exp);
      end
      if (k == 0) begin
        checks++;
        if (bus0.cpu_hit !== 1'b1) begin
          fails++;
          $display("[TB] FAIL read_hit got %b required 1", bus0.cpu_hit);
        end
      end
      if (k == 1) begin
        checks++;
        if (bus0.mem_adr !== 13'h0123) begin
          fails++;
          $display("[TB] FAIL read_adr got %h required 0123", bus0.mem_adr);
        end
      end
      if (k >= 3) begin
        checks++;
        if (bus0.cpu_rdata !== 8'h5A) begin
          fails++;
          $display("[TB] FAIL read_data k=%0d got %h required 5a", k, bus0.cpu_rdata);
        end
      end
      if (k == 4) bus0.cpu_rd = 1'b0;
    end
  endtask

  // Request dropped and address moved right after accept: still completes.
  task automatic test_drop();
    logic [3:0] exp;
    @(posedge clk); #1;
    bus0.cpu_adr = 16'hC010; bus0.cpu_rd = 1'b1;
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      exp = {k == 1, 1'b0, k == 3, (k >= 1 && k <= 3)};
      checks++;
      if ({bus0.mem_ce, bus0.mem_we, bus0.cpu_ack, bus0.cpu_busy} !== exp) begin
        fails++;
        $display("[TB] FAIL drop_ctl k=%0d got ce/we/ack/busy=%b required %b", k,
                 {bus0.mem_ce, bus0.mem_we, bus0.cpu_ack, bus0.cpu_busy}, exp);
      end
      if (k == 1) begin
        checks++;
        if (bus0.mem_adr !== 13'h0010) begin
          fails++;
          $display("[TB] FAIL drop_adr got %h required 0010", bus0.mem_adr);
        end
        bus0.cpu_rd = 1'b0;
        bus0.cpu_adr = 16'h0000;
      end
      if (k >= 3) begin
        checks++;
        if (bus0.cpu_rdata !== 8'h3C) begin
          fails++;
          $display("[TB] FAIL drop_data k=%0d got %h required 3c", k, bus0.cpu_rdata);
        end
      end
    end
  endtask

  // Addresses just outside the window are ignored; edges inside decode as hits.
  task automatic test_miss();
    logic [15:0] miss_adrs [2];
    logic [15:0] hit_adrs [2];
    miss_adrs = '{16'hBFFF, 16'hE000};
    hit_adrs  = '{16'hC000, 16'hDFFF};
    for (int a = 0; a < 2; a++) begin
      @(posedge clk); #1;
      bus0.cpu_adr = miss_adrs[a]; bus0.cpu_rd = 1'b1;
      for (int k = 0; k <= 4; k++) begin
        @(negedge clk);
        checks++;
        if ({bus0.cpu_hit, bus0.mem_ce, bus0.cpu_ack, bus0.cpu_busy} !== 4'b0000) begin
          fails++;
          $display("[TB] FAIL miss_%h k=%0d got hit/ce/ack/busy=%b required 0000", miss_adrs[a], k,
                   {bus0.cpu_hit, bus0.mem_ce, bus0.cpu_ack, bus0.cpu_busy});
        end
      end
      bus0.cpu_rd = 1'b0;
    end
    for (int a = 0; a < 2; a++) begin
      bus0.cpu_adr = hit_adrs[a];
      @(negedge clk);
      checks++;
      if (bus0.cpu_hit !== 1'b1) begin
        fails++;
        $display("[TB] FAIL edge_hit_%h got %b required 1", hit_adrs[a], bus0.cpu_hit);
      end
    end
    bus0.cpu_adr = 16'h0000;
  endtask

  // rd and wr together on a hit: sticky err, no access; cleared only by reset.
  task automatic test_err();
    logic exp_err;
    @(posedge clk); #1;
    bus0.cpu_adr = 16'hC000; bus0.cpu_rd = 1'b1; bus0.cpu_wr = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      exp_err = (k >= 1);
      checks++;
      if ({bus0.err, bus0.mem_ce, bus0.cpu_ack, bus0.cpu_busy} !== {exp_err, 3'b000}) begin
        fails++;
        $display("[TB] FAIL err_flag k=%0d got err/ce/ack/busy=%b required %b", k,
                 {bus0.err, bus0.mem_ce, bus0.cpu_ack, bus0.cpu_busy}, {exp_err, 3'b000});
      end
      if (k == 3) begin
        bus0.cpu_rd = 1'b0; bus0.cpu_wr = 1'b0;
      end
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus0.err !== 1'b0) begin
      fails++;
      $display("[TB] FAIL err_clear got %b required 0", bus0.err);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // W=2 write to DFFF held 10 cycles: one ce with we, ack at k=5, then HOLD.
  task automatic test_write_hold();
    logic [3:0] exp;
    @(posedge clk); #1;
    bus2.cpu_adr = 16'hDFFF; bus2.cpu_wr = 1'b1; bus2.cpu_wdata = 8'hA5;
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      exp = {k == 1, k == 1, k == 5, (k >= 1 && k <= 5)};
      checks++;
      if ({bus2.mem_ce, bus2.mem_we, bus2.cpu_ack, bus2.cpu_busy} !== exp) begin
        fails++;
        $display("[TB] FAIL write_ctl k=%0d got ce/we/ack/busy=%b required %b", k,
                 {bus2.mem_ce, bus2.mem_we, bus2.cpu_ack, bus2.cpu_busy}, exp);
      end
      if (k == 1) begin
        checks++;
        if ({bus2.mem_adr, bus2.mem_wdata} !== {13'h1FFF, 8'hA5}) begin
          fails++;
          $display("[TB] FAIL write_cmd got adr=%h wdata=%h required 1fff/a5",
                   bus2.mem_adr, bus2.mem_wdata);
        end
        bus2.cpu_wdata = 8'h00;
      end
      if (k == 10) bus2.cpu_wr = 1'b0;
    end
    checks++;
    if (ram2[13'h1FFF] !== 8'hA5) begin
      fails++;
      $display("[TB] FAIL write_ram got %h required a5", ram2[13'h1FFF]);
    end
    @(posedge clk); #1;
    bus2.cpu_rd = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      exp = {k == 1, 1'b0, k == 5, (k >= 1 && k <= 5)};
      checks++;
      if ({bus2.mem_ce, bus2.mem_we, bus2.cpu_ack, bus2.cpu_busy} !== exp) begin
        fails++;
        $display("[TB] FAIL readback_ctl k=%0d got ce/we/ack/busy=%b required %b", k,
                 {bus2.mem_ce, bus2.mem_we, bus2.cpu_ack, bus2.cpu_busy}, exp);
      end
      if (k == 5) begin
        checks++;
        if (bus2.cpu_rdata !== 8'hA5) begin
          fails++;
          $display("[TB] FAIL readback_data got %h required a5", bus2.cpu_rdata);
        end
        bus2.cpu_rd = 1'b0;
      end
    end
  endtask

  // W=3: reset during WAIT kills the transaction; a fresh read then acks at k=6.
  task automatic test_reset_mid();
    logic [3:0] exp;
    @(posedge clk); #1;
    bus3.cpu_adr = 16'hC000; bus3.cpu_rd = 1'b1;
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      exp = {k == 1, 1'b0, 1'b0, k >= 1};
      checks++;
      if ({bus3.mem_ce, bus3.mem_we, bus3.cpu_ack, bus3.cpu_busy} !== exp) begin
        fails++;
        $display("[TB] FAIL mid_ctl k=%0d got ce/we/ack/busy=%b required %b", k,
                 {bus3.mem_ce, bus3.mem_we, bus3.cpu_ack, bus3.cpu_busy}, exp);
      end
      if (k == 3) begin
        checks++;
        if (bus3.cpu_rdata !== 8'h77) begin
          fails++;
          $display("[TB] FAIL mid_capture got %h required 77", bus3.cpu_rdata);
        end
      end
    end
    reset_n = 1'b0;
    #1;
    bus3.cpu_rd = 1'b0;
    checks++;
    if ({bus3.cpu_rdata, bus3.cpu_ack, bus3.cpu_busy, bus3.mem_ce, bus3.mem_we,
         bus3.mem_adr, bus3.mem_wdata} !== 33'd0) begin
      fails++;
      $display("[TB] FAIL mid_reset got rdata=%h ack=%b busy=%b adr=%h required all zero",
               bus3.cpu_rdata, bus3.cpu_ack, bus3.cpu_busy, bus3.mem_adr);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if ({bus3.cpu_ack, bus3.cpu_busy} !== 2'b00) begin
        fails++;
        $display("[TB] FAIL mid_noack k=%0d got ack/busy=%b required 00", k,
                 {bus3.cpu_ack, bus3.cpu_busy});
      end
    end
    reset_n = 1'b1;
    @(posedge clk); #1;
    bus3.cpu_adr = 16'hC000; bus3.cpu_rd = 1'b1;
    for (int k = 0; k <= 7; k++) begin
      @(negedge clk);
      exp = {k == 1, 1'b0, k == 6, (k >= 1 && k <= 6)};
      checks++;
      if ({bus3.mem_ce, bus3.mem_we, bus3.cpu_ack, bus3.cpu_busy} !== exp) begin
        fails++;
        $display("[TB] FAIL after_ctl k=%0d got ce/we/ack/busy=%b required %b", k,
                 {bus3.mem_ce, bus3.mem_we, bus3.cpu_ack, bus3.cpu_busy}, exp);
      end
      if (k == 6) begin
        checks++;
        if (bus3.cpu_rdata !== 8'h77) begin
          fails++;
          $display("[TB] FAIL after_data got %h required 77", bus3.cpu_rdata);
        end
        bus3.cpu_rd = 1'b0;
      end
    end
  endtask

  // Write C200=11, drop at ack, read C200 right after: second ce at k=5, ack k=7.
  task automatic test_back_to_back();
    logic [3:0] exp;
    @(posedge clk); #1;
    bus0.cpu_adr = 16'hC200; bus0.cpu_wr = 1'b1; bus0.cpu_wdata = 8'h11;
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      exp = {(k == 1 || k == 5), k == 1, (k == 3 || k == 7),
             ((k >= 1 && k <= 3) || (k >= 5 && k <= 7))};
      checks++;
      if ({bus0.mem_ce, bus0.mem_we, bus0.cpu_ack, bus0.cpu_busy} !== exp) begin
        fails++;
        $display("[TB] FAIL b2b_ctl k=%0d got ce/we/ack/busy=%b required %b", k,
                 {bus0.mem_ce, bus0.mem_we, bus0.cpu_ack, bus0.cpu_busy}, exp);
      end
      if (k == 3) bus0.cpu_wr = 1'b0;
      if (k == 4) bus0.cpu_rd = 1'b1;
      if (k == 7) begin
        checks++;
        if (bus0.cpu_rdata !== 8'h11) begin
          fails++;
          $display("[TB] FAIL b2b_data got %h required 11", bus0.cpu_rdata);
        end
        bus0.cpu_rd = 1'b0;
      end
    end
  endtask

  initial begin
    idle_all();
    bus0.mem_rdata = 8'h00; bus2.mem_rdata = 8'h00; bus3.mem_rdata = 8'h00;
    test_reset();
    test_read();
    test_drop();
    test_miss();
    test_err();
    test_write_hold();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired after %0d checks", checks);
    $fatal(1, "[TB] watchdog");
  end

endmodule
